// File: rtl/ifetch_unit_pkg.sv
// Shared CPU front-end definitions: reset PC, fetch buffering depth and the
// {pc, instr} record carried from fetch to decode.
package cpu_defs;

    localparam logic [31:0] PC_BEGIN    = 32'h3000;
    localparam int          FETCH_DEPTH = 2;
    localparam int          INSTR_W     = 32;
    localparam int          PC_W        = 32;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [PC_W-1:0] wordAlign(input logic [PC_W-1:0] addr);
        return {addr[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// Fetch-stage bus: PC stage hookup, instruction memory handshake and the
// IF/ID valid/ready boundary. master is the fetch unit, slave its environment.
interface ifetch_unit_if;
    import cpu_defs::*;

    logic [PC_W-1:0]    Pc;
    logic               Flush;
    logic               Stall;
    logic               ImemReq;
    logic [PC_W-1:0]    ImemAddr;
    logic               ImemGnt;
    logic               ImemRvalid;
    logic [INSTR_W-1:0] ImemRdata;
    logic               IfValid;
    logic [INSTR_W-1:0] IfInstr;
    logic [PC_W-1:0]    IfPc;
    logic               IdReady;

    modport master (
        input  Pc, Flush, ImemGnt, ImemRvalid, ImemRdata, IdReady,
        output Stall, ImemReq, ImemAddr, IfValid, IfInstr, IfPc
    );

    modport slave (
        output Pc, Flush, ImemGnt, ImemRvalid, ImemRdata, IdReady,
        input  Stall, ImemReq, ImemAddr, IfValid, IfInstr, IfPc
    );

endinterface

// File: rtl/ifetch_unit_sync_fifo.sv
// Small synchronous FIFO with registered storage; the head entry is read
// straight from storage, clear empties it in one cycle with priority.
module sync_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 2,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wrPtr_q, wrPtr_d;
    logic [PW-1:0]    rdPtr_q, rdPtr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             doPush, doPop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign rdata_o = mem_q[rdPtr_q];

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign doPush = push_i && (!full_o || pop_i);
    assign doPop  = pop_i && !empty_o;

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (clear_i) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (doPush) wrPtr_d = wrPtr_q + PW'(1);
            if (doPop)  rdPtr_d = rdPtr_q + PW'(1);
            count_d = count_q + CW'(doPush) - CW'(doPop);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush && !clear_i) mem_q[wrPtr_q] <= wdata_i;
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: credit-limited in-order requests to instruction
// memory, a PC-tagged return buffer toward decode, and flush-time discarding.
module ifetch_unit
    import cpu_defs::*;
#(
    parameter int DEPTH  = FETCH_DEPTH,
    parameter int ADDR_W = 32
) (
    input  logic          Clk,
    input  logic          Reset,
    ifetch_unit_if.master bus
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] pcqHead;
    logic [CW-1:0]     pend;
    logic              pcqFull, pcqEmpty;
    fetch_entry_t      bufHead, bufIn;
    logic [CW-1:0]     bufCount;
    logic              bufFull, bufEmpty;
    logic [CW-1:0]     drop_q, drop_d;
    logic [CW:0]       used;
    logic              accept, bufPush, bufPop;

    // Credit counts the head leaving this cycle, so a DEPTH=2 pipe sustains
    // one instruction per cycle while still never over-committing the buffer.
    assign bufPop  = !bufEmpty && bus.IdReady && !bus.Flush;
    assign used    = (CW+1)'(pend) + (CW+1)'(bufCount) - (CW+1)'(bufPop);

    assign bus.ImemReq  = !Reset && !bus.Flush && (used < (CW+1)'(DEPTH));
    assign bus.ImemAddr = {bus.Pc[ADDR_W-1:2], 2'b00};
    assign accept       = bus.ImemReq && bus.ImemGnt;
    assign bus.Stall    = !accept && !bus.Flush;

    assign bufPush = bus.ImemRvalid && !bus.Flush && (drop_q == '0);
    assign bufIn   = '{pc: pcqHead, instr: bus.ImemRdata};

    sync_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) pcq (
        .Clk     (Clk),
        .Reset   (Reset),
        .push_i  (accept),
        .pop_i   (bus.ImemRvalid),
        .clear_i (1'b0),
        .wdata_i (bus.Pc),
        .rdata_o (pcqHead),
        .count_o (pend),
        .full_o  (pcqFull),
        .empty_o (pcqEmpty)
    );

    sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) outBuf (
        .Clk     (Clk),
        .Reset   (Reset),
        .push_i  (bufPush),
        .pop_i   (bufPop),
        .clear_i (bus.Flush),
        .wdata_i (bufIn),
        .rdata_o (bufHead),
        .count_o (bufCount),
        .full_o  (bufFull),
        .empty_o (bufEmpty)
    );

    // On Flush everything still outstanding is wrong-path, except a word
    // returning right now, which is discarded on the spot.
    always_comb begin
        drop_d = drop_q;
        if (bus.Flush)
            drop_d = pend - CW'(bus.ImemRvalid);
        else if (bus.ImemRvalid && drop_q != '0)
            drop_d = drop_q - CW'(1);
    end

    always_ff @(posedge Clk) begin
        if (Reset) drop_q <= '0;
        else       drop_q <= drop_d;
    end

    assign bus.IfValid = !bufEmpty;
    assign bus.IfPc    = bufHead.pc;
    assign bus.IfInstr = bufHead.instr;

    a_noBufOverflow: assert property (@(posedge Clk) disable iff (Reset)
        !(bufPush && bufFull && !bufPop));
    a_noPcqOverflow: assert property (@(posedge Clk) disable iff (Reset)
        !(accept && pcqFull));
    a_noOrphanRvalid: assert property (@(posedge Clk) disable iff (Reset)
        !(bus.ImemRvalid && pcqEmpty));

endmodule
